// File: rtl/hsfir_pkg.sv
// Shared definitions for the half-band FIR and its decimating output stage.
// Holds sample/warm-up defaults, the FIFO pointer-width helper and the stage state type.
package hsfir_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int WARMUP_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    ST_WARM,
    ST_RUN
  } dec_state_t;

  // Address bits for a power-of-2 FIFO; pointers carry one more bit for full/empty.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hsfir_fifo.sv
// First-word-fall-through FIFO: the head sample is visible on o_data whenever non-empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module hsfir_fifo
  import hsfir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  localparam int AW        = ptrWidth(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [AW:0]           o_level
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wrPtr;
  logic [AW:0]           r_rdPtr;
  logic                  w_doPush;
  logic                  w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_level  = r_wrPtr - r_rdPtr;
  assign o_data   = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage needs no reset: o_data is forced to zero while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/hsfir_decimator.sv
// Drops the FIR warm-up transient, keeps every other sample on a latched phase,
// and queues kept samples behind a valid/ready handshake with a sticky overflow flag.
module hsfir_decimator
  import hsfir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WARMUP     = WARMUP_DEF,
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  localparam int LW        = ptrWidth(DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_phase,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [LW-1:0]         o_level,
  output logic                  o_overflow
);

  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  dec_state_t    r_state;
  logic [CW-1:0] r_warmCnt;
  logic          r_phase;
  logic          r_toggle;
  logic          r_overflow;
  logic          w_keep;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;

  assign w_keep     = (r_state == ST_RUN) && (r_toggle == r_phase);
  assign o_valid    = !w_empty;
  assign w_pop      = o_valid && i_ready;
  assign o_overflow = r_overflow;

  // The edge that discards the last warm-up sample also latches the phase for the whole run.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_WARM;
      r_warmCnt  <= '0;
      r_phase    <= 1'b0;
      r_toggle   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_WARM: begin
          r_warmCnt <= r_warmCnt + 1'b1;
          if (r_warmCnt == CW'(WARMUP - 1)) begin
            r_state  <= ST_RUN;
            r_phase  <= i_phase;
            r_toggle <= 1'b0;
          end
        end
        ST_RUN: begin
          r_toggle <= ~r_toggle;
          if (w_keep && w_full && !w_pop) r_overflow <= 1'b1;
        end
        default: r_state <= ST_WARM;
      endcase
    end
  end

  hsfir_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_push   (w_keep),
    .i_data   (i_data),
    .i_pop    (w_pop),
    .o_data   (o_data),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_level  (o_level)
  );

endmodule

// File: tb/tb_hsfir_decimator.sv
// Bench for hsfir_decimator: ramp input, random handshake, queue-based reference model.
module tb_hsfir_decimator;

  localparam int DW     = 8;
  localparam int WARMUP = 8;
  localparam int DEPTH  = 4;
  localparam int LW     = 3;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic [DW-1:0] i_data;
  logic          i_phase;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic [LW-1:0] o_level;
  logic          o_overflow;

  int checks = 0;
  int passes = 0;

  // Reference model: sample index since release, latched phase, queue of kept samples.
  int                 edgeN;
  bit                 mPhase;
  int                 q[$];
  bit                 mOvf;
  logic [DW+LW+1:0]   expVec;

  always #5 i_clk = ~i_clk;

  hsfir_decimator #(
    .DATA_WIDTH(DW),
    .WARMUP    (WARMUP),
    .DEPTH     (DEPTH)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_data    (i_data),
    .i_phase   (i_phase),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_level   (o_level),
    .o_overflow(o_overflow)
  );

  task automatic updateExpected();
    logic [DW-1:0] head;
    head   = (q.size() > 0) ? DW'(q[0]) : '0;
    expVec = {q.size() > 0, head, LW'(q.size()), mOvf};
  endtask

  // One clock edge for DUT and model; returns 1 ns after the edge with the next ramp value applied.
  task automatic stepCycle();
    bit pop;
    bit keep;
    int dummy;
    @(posedge i_clk);
    pop = (q.size() > 0) && i_ready;
    if (edgeN == WARMUP - 1) mPhase = i_phase;
    keep = (edgeN >= WARMUP) && (((edgeN - WARMUP) % 2) == int'(mPhase));
    if (pop) dummy = q.pop_front();
    if (keep) begin
      if (q.size() < DEPTH) q.push_back(int'(i_data));
      else mOvf = 1'b1;
    end
    edgeN++;
    updateExpected();
    #1;
    i_data = DW'(edgeN);
  endtask

  task automatic modelClear(input bit phase);
    q.delete();
    mOvf   = 1'b0;
    mPhase = 1'b0;
    edgeN  = 0;
    i_phase = phase;
    updateExpected();
  endtask

  task automatic doReset(input bit phase);
    #2;
    i_reset_n = 1'b0;
    modelClear(phase);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    i_data    = '0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_data    = 8'h5a;
    i_phase   = 1'b0;
    i_ready   = 1'b1;
    modelClear(1'b0);
    #12;
    checks++;
    if ({o_valid, o_level, o_overflow} !== '0) $display("[TB] FAIL reset_flags: got %b expected 0", {o_valid, o_level, o_overflow});
    else passes++;
    checks++;
    if (o_data !== '0) $display("[TB] FAIL reset_data: got %h expected 00", o_data);
    else passes++;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    i_data    = '0;
  endtask

  task automatic test_phase0();
    doReset(1'b0);
    i_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      checks++;
      if ({o_valid, o_data, o_level, o_overflow} !== expVec)
        $display("[TB] FAIL phase0_model cyc %0d: got %h expected %h", i, {o_valid, o_data, o_level, o_overflow}, expVec);
      else passes++;
      checks++;
      if (o_level > 1) $display("[TB] FAIL phase0_level cyc %0d: got %0d expected <=1", i, o_level);
      else passes++;
      if (i == 7) begin
        checks++;
        if (o_valid !== 1'b0) $display("[TB] FAIL phase0_warm_valid: got %b expected 0", o_valid);
        else passes++;
      end
      if (i == 8) begin
        checks++;
        if ({o_valid, o_data} !== {1'b1, 8'd8}) $display("[TB] FAIL phase0_first: got %b/%0d expected 1/8", o_valid, o_data);
        else passes++;
      end
    end
  endtask

  task automatic test_phase1();
    doReset(1'b1);
    i_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i >= 8) i_phase = 1'($urandom);
      stepCycle();
      checks++;
      if ({o_valid, o_data, o_level, o_overflow} !== expVec)
        $display("[TB] FAIL phase1_model cyc %0d: got %h expected %h", i, {o_valid, o_data, o_level, o_overflow}, expVec);
      else passes++;
      if (i == 9) begin
        checks++;
        if ({o_valid, o_data} !== {1'b1, 8'd9}) $display("[TB] FAIL phase1_first: got %b/%0d expected 1/9", o_valid, o_data);
        else passes++;
      end
      if (i == 11) begin
        checks++;
        if ({o_valid, o_data} !== {1'b1, 8'd11}) $display("[TB] FAIL phase1_second: got %b/%0d expected 1/11", o_valid, o_data);
        else passes++;
      end
    end
  endtask

  task automatic test_overflow();
    int got[$];
    doReset(1'b0);
    i_ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      stepCycle();
      checks++;
      if ({o_valid, o_data, o_level, o_overflow} !== expVec)
        $display("[TB] FAIL ovf_model cyc %0d: got %h expected %h", i, {o_valid, o_data, o_level, o_overflow}, expVec);
      else passes++;
      if (i == 14) begin
        checks++;
        if ({o_level, o_overflow} !== {3'd4, 1'b0}) $display("[TB] FAIL ovf_full: got %0d/%b expected 4/0", o_level, o_overflow);
        else passes++;
      end
    end
    checks++;
    if ({o_level, o_overflow} !== {3'd4, 1'b1}) $display("[TB] FAIL ovf_drop: got %0d/%b expected 4/1", o_level, o_overflow);
    else passes++;
    i_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (o_valid && i_ready) got.push_back(int'(o_data));
      stepCycle();
      checks++;
      if ({o_valid, o_data, o_level, o_overflow} !== expVec)
        $display("[TB] FAIL ovf_drain_model cyc %0d: got %h expected %h", i, {o_valid, o_data, o_level, o_overflow}, expVec);
      else passes++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got.size() <= k) $display("[TB] FAIL ovf_drain_%0d: got none expected %0d", k, 8 + 2 * k);
      else if (got[k] != 8 + 2 * k) $display("[TB] FAIL ovf_drain_%0d: got %0d expected %0d", k, got[k], 8 + 2 * k);
      else passes++;
    end
    checks++;
    if (o_overflow !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", o_overflow);
    else passes++;
  endtask

  task automatic test_full_pop();
    doReset(1'b0);
    i_ready = 1'b0;
    for (int i = 0; i <= 15; i++) stepCycle();
    checks++;
    if (o_level !== 3'd4) $display("[TB] FAIL fullpop_pre: got %0d expected 4", o_level);
    else passes++;
    i_ready = 1'b1;
    stepCycle();
    checks++;
    if ({o_level, o_overflow, o_data} !== {3'd4, 1'b0, 8'd10})
      $display("[TB] FAIL fullpop_edge: got %0d/%b/%0d expected 4/0/10", o_level, o_overflow, o_data);
    else passes++;
    checks++;
    if ({o_valid, o_data, o_level, o_overflow} !== expVec)
      $display("[TB] FAIL fullpop_model: got %h expected %h", {o_valid, o_data, o_level, o_overflow}, expVec);
    else passes++;
  endtask

  task automatic test_random_ready();
    logic          prevV;
    logic          prevR;
    logic [DW-1:0] prevD;
    int            got[$];
    bit            seqOk;
    doReset(1'($urandom));
    for (int i = 0; i < 200; i++) begin
      i_ready = 1'($urandom);
      prevV = o_valid;
      prevR = i_ready;
      prevD = o_data;
      if (o_valid && i_ready) got.push_back(int'(o_data));
      stepCycle();
      checks++;
      if ({o_valid, o_data, o_level, o_overflow} !== expVec)
        $display("[TB] FAIL rand_model cyc %0d: got %h expected %h", i, {o_valid, o_data, o_level, o_overflow}, expVec);
      else passes++;
      if (prevV && !prevR) begin
        checks++;
        if ({o_valid, o_data} !== {1'b1, prevD})
          $display("[TB] FAIL rand_hold cyc %0d: got %b/%h expected 1/%h", i, o_valid, o_data, prevD);
        else passes++;
      end
    end
    seqOk = (got.size() > 10);
    for (int k = 1; k < got.size(); k++) if (got[k] - got[k-1] != 2 && !mOvf) seqOk = 1'b0;
    checks++;
    if (!seqOk) $display("[TB] FAIL rand_sequence: got %0d samples, not stepping by 2", got.size());
    else passes++;
  endtask

  task automatic test_reset_mid();
    doReset(1'b0);
    i_ready = 1'b0;
    for (int i = 0; i < 20; i++) stepCycle();
    #3;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_level, o_overflow, o_data} !== '0)
      $display("[TB] FAIL midreset_async: got %b/%0d/%b/%h expected 0/0/0/00", o_valid, o_level, o_overflow, o_data);
    else passes++;
    modelClear(1'b0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    i_data    = '0;
    i_ready   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      checks++;
      if ({o_valid, o_data, o_level, o_overflow} !== expVec)
        $display("[TB] FAIL midreset_model cyc %0d: got %h expected %h", i, {o_valid, o_data, o_level, o_overflow}, expVec);
      else passes++;
      if (i < 8) begin
        checks++;
        if (o_valid !== 1'b0) $display("[TB] FAIL midreset_warm cyc %0d: got %b expected 0", i, o_valid);
        else passes++;
      end
      if (i == 8) begin
        checks++;
        if ({o_valid, o_data} !== {1'b1, 8'd8}) $display("[TB] FAIL midreset_first: got %b/%0d expected 1/8", o_valid, o_data);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_phase0();
    test_phase1();
    test_overflow();
    test_full_pop();
    test_random_ready();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
